// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage with ALU and HI/LO passthrough plus a req/ack load/store unit.
// Aligned accesses stall the pipeline until ack or a bounded-wait timeout; misaligned ones trap.
module mem_lsu #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic [31:0]           wdata_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  whilo_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_sdata_i,
  output logic [31:0]           wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  whilo_o,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_W-1:0]     dbus_addr,
  output logic [3:0]            dbus_be,
  output logic [31:0]           dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [31:0]           dbus_rdata,
  output logic                  stallreq_o,
  output logic                  exc_adel_o,
  output logic                  exc_ades_o,
  output logic                  bus_err_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  state_t          state, state_d;
  bus_req_t        req_q, req_d;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     ld_data, ld_ext;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            timed_out;
  logic            is_load, is_store, sz_byte, sz_half, sz_word;
  logic            misaligned, access;
  logic            ack_hit, tmo_hit;
  logic            unused_stall;

  // Only stall[4] (MEM/WB hold) matters to this stage.
  assign unused_stall = ^{stall[5], stall[3:0]};

  // Op decode: class and access size.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_byte  = 1'b0;
    sz_half  = 1'b0;
    sz_word  = 1'b0;
    case (mem_op_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_LW:         begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; sz_word = 1'b1; end
      default: ;
    endcase
  end

  assign misaligned = (sz_half & mem_addr_i[0]) | (sz_word & (mem_addr_i[1:0] != 2'b00));
  assign access     = (is_load | is_store) & ~misaligned;
  assign ack_hit    = (state == S_BUSY) & dbus_ack;
  assign tmo_hit    = (state == S_BUSY) & ~dbus_ack & (cnt == CNT_LAST);

  // Bus request payload: word-aligned address, lane enables, lane-replicated store data.
  always_comb begin
    req_d.we    = is_store;
    req_d.addr  = {mem_addr_i[ADDR_W-1:2], 2'b00};
    req_d.be    = 4'b1111;
    req_d.wdata = mem_sdata_i;
    if (sz_byte) begin
      req_d.be    = BE_W'(4'b0001 << mem_addr_i[1:0]);
      req_d.wdata = {4{mem_sdata_i[7:0]}};
    end else if (sz_half) begin
      req_d.be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      req_d.wdata = {2{mem_sdata_i[15:0]}};
    end
  end

  // Load lane select and extension, applied at capture time.
  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    ld_byte = dbus_rdata[7:0];
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = mem_addr_i[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (mem_op_i)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dbus_rdata;
    endcase
  end

  // Next state and stage outputs; everything reads as zero while reset is held.
  always_comb begin
    state_d    = state;
    stallreq_o = 1'b0;
    wdata_o    = wdata_i;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    hi_o       = hi_i;
    lo_o       = lo_i;
    whilo_o    = whilo_i;
    exc_adel_o = is_load & misaligned;
    exc_ades_o = is_store & misaligned;
    case (state)
      S_IDLE: begin
        if (is_load | is_store) wreg_o = 1'b0;
        if (access) begin
          stallreq_o = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (ack_hit | tmo_hit) state_d = S_DONE;
      end
      S_DONE: begin
        wreg_o = is_load & ~timed_out & wreg_i;
        if (is_load) wdata_o = ld_data;
        if (!stall[4]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst) begin
      state_d    = S_IDLE;
      stallreq_o = 1'b0;
      wdata_o    = '0;
      wd_o       = '0;
      wreg_o     = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      whilo_o    = 1'b0;
      exc_adel_o = 1'b0;
      exc_ades_o = 1'b0;
    end
  end

  // State, bus request, wait counter and load-result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      req_q     <= '0;
      dbus_req  <= 1'b0;
      cnt       <= '0;
      ld_data   <= '0;
      timed_out <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state     <= state_d;
      bus_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            dbus_req  <= 1'b1;
            req_q     <= req_d;
            cnt       <= '0;
            timed_out <= 1'b0;
          end
        end
        S_BUSY: begin
          if (dbus_ack) begin
            ld_data   <= ld_ext;
            dbus_req  <= 1'b0;
            req_q.we  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            ld_data   <= '0;
            dbus_req  <= 1'b0;
            req_q.we  <= 1'b0;
            timed_out <= 1'b1;
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dbus_we    = req_q.we;
  assign dbus_addr  = req_q.addr;
  assign dbus_be    = req_q.be;
  assign dbus_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a scoreboard of expected stage results.
module tb_mem_lsu;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, mem_sdata_i, dbus_rdata;
  logic [4:0]  wd_i;
  logic        wreg_i, whilo_i, dbus_ack;
  logic [3:0]  mem_op_i;
  logic [31:0] wdata_o, hi_o, lo_o, dbus_addr, dbus_wdata;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, dbus_req, dbus_we, stallreq_o;
  logic        exc_adel_o, exc_ades_o, bus_err_o;
  logic [3:0]  dbus_be;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .stallreq_o(stallreq_o), .exc_adel_o(exc_adel_o), .exc_ades_o(exc_ades_o),
    .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_empty observed=%h expected=<queued entry>", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  // Present one access, ack it in BUSY cycle ack_at (0 = never), stop sampling in DONE.
  task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input int ack_at, input logic [31:0] rdata,
                            output int stall_cycles, output int err_pulses,
                            output logic snap_we, output logic [31:0] snap_addr,
                            output logic [3:0] snap_be, output logic [31:0] snap_wdata);
    int cyc;
    @(negedge clk);
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata; dbus_ack = 1'b0;
    stall_cycles = 0; err_pulses = 0; cyc = 0;
    snap_we = 1'b0; snap_addr = '0; snap_be = '0; snap_wdata = '0;
    #1;
    while (stallreq_o && cyc < 64) begin
      stall_cycles++;
      @(negedge clk);
      cyc++;
      dbus_ack   = (cyc == ack_at);
      dbus_rdata = (cyc == ack_at) ? rdata : 32'h0;
      #1;
      if (cyc == 1) begin
        chk("busy_req", 32'(dbus_req), 32'h1);
        snap_we = dbus_we; snap_addr = dbus_addr; snap_be = dbus_be; snap_wdata = dbus_wdata;
      end
      if (bus_err_o) err_pulses++;
    end
    dbus_ack = 1'b0;
    if (cyc >= 64) chk("wait_bound", 32'(stallreq_o), 32'h0);
  endtask

  // Let MEM/WB consume the result and return the stage to IDLE with no op.
  task automatic finish_txn();
    stall = 6'b0;
    mem_op_i = OP_NONE;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, ep;
    logic s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_be;

    rst = 1'b0; stall = 6'b0; mem_op_i = OP_NONE; mem_addr_i = '0; mem_sdata_i = '0;
    dbus_ack = 1'b0; dbus_rdata = '0;
    wdata_i = 32'hA5A5A5A5; wd_i = 5'd9; wreg_i = 1'b1;
    hi_i = 32'h1111_1111; lo_i = 32'h2222_2222; whilo_i = 1'b1;

    // Reset: everything reads zero even with live inputs
    repeat (2) @(negedge clk);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_wd", 32'(wd_o), 32'h0);
    chk("rst_wreg", 32'(wreg_o), 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_whilo", 32'(whilo_o), 32'h0);
    chk("rst_req", 32'(dbus_req), 32'h0);
    chk("rst_be", 32'(dbus_be), 32'h0);
    chk("rst_stall", 32'(stallreq_o), 32'h0);
    rst = 1'b1;

    // ALU and HI/LO passthrough
    @(negedge clk);
    wdata_i = 32'h12345678; wd_i = 5'd3; wreg_i = 1'b1; whilo_i = 1'b1;
    hi_i = 32'hCAFE0001; lo_i = 32'hCAFE0002;
    #1;
    chk("pt_wdata", wdata_o, 32'h12345678);
    chk("pt_wd", 32'(wd_o), 32'd3);
    chk("pt_wreg", 32'(wreg_o), 32'h1);
    chk("pt_whilo", 32'(whilo_o), 32'h1);
    chk("pt_hi", hi_o, 32'hCAFE0001);
    chk("pt_lo", lo_o, 32'hCAFE0002);
    chk("pt_stall", 32'(stallreq_o), 32'h0);
    mem_op_i = 4'hF;
    #1;
    chk("pt_badop_wdata", wdata_o, 32'h12345678);
    chk("pt_badop_stall", 32'(stallreq_o), 32'h0);

    // LW with ack in the third BUSY cycle
    wdata_i = 32'h0BAD0BAD; wd_i = 5'd7;
    sb_push("lw_wdata", 32'hDEADBEEF);
    sb_push("lw_wreg", 32'h1);
    run_access(OP_LW, 32'h100, 32'h0, 3, 32'hDEADBEEF, sc, ep, s_we, s_addr, s_be, s_wdata);
    chk("lw_be", 32'(s_be), 32'hF);
    chk("lw_addr", s_addr, 32'h100);
    chk("lw_we", 32'(s_we), 32'h0);
    chk("lw_stall_cycles", 32'(sc), 32'd4);
    sb_check(wdata_o);
    sb_check(32'(wreg_o));
    chk("lw_wd", 32'(wd_o), 32'd7);
    chk("lw_hilo", hi_o, 32'hCAFE0001);
    stall = 6'b010000;
    @(negedge clk);
    #1;
    chk("lw_hold_wdata", wdata_o, 32'hDEADBEEF);
    chk("lw_hold_stall", 32'(stallreq_o), 32'h0);
    finish_txn();
    chk("lw_idle_req", 32'(dbus_req), 32'h0);

    // Sub-word loads from rdata 0x80112233
    sb_push("lb_wdata", 32'hFFFFFF80);
    run_access(OP_LB, 32'h103, 32'h0, 1, 32'h80112233, sc, ep, s_we, s_addr, s_be, s_wdata);
    chk("lb_be", 32'(s_be), 32'h8);
    chk("lb_addr", s_addr, 32'h100);
    chk("lb_stall_cycles", 32'(sc), 32'd2);
    sb_check(wdata_o);
    finish_txn();

    sb_push("lbu_wdata", 32'h00000080);
    run_access(OP_LBU, 32'h103, 32'h0, 2, 32'h80112233, sc, ep, s_we, s_addr, s_be, s_wdata);
    sb_check(wdata_o);
    finish_txn();

    sb_push("lh_wdata", 32'hFFFF8011);
    run_access(OP_LH, 32'h102, 32'h0, 1, 32'h80112233, sc, ep, s_we, s_addr, s_be, s_wdata);
    chk("lh_be", 32'(s_be), 32'hC);
    sb_check(wdata_o);
    finish_txn();

    sb_push("lhu_wdata", 32'h00002233);
    sb_push("lhu_wreg", 32'h1);
    run_access(OP_LHU, 32'h100, 32'h0, 5, 32'h80112233, sc, ep, s_we, s_addr, s_be, s_wdata);
    chk("lhu_be", 32'(s_be), 32'h3);
    chk("lhu_stall_cycles", 32'(sc), 32'd6);
    sb_check(wdata_o);
    sb_check(32'(wreg_o));
    finish_txn();

    // Stores: lane enables and replication, never a register write
    sb_push("sh_wreg", 32'h0);
    run_access(OP_SH, 32'h102, 32'h0000ABCD, 2, 32'h0, sc, ep, s_we, s_addr, s_be, s_wdata);
    chk("sh_we", 32'(s_we), 32'h1);
    chk("sh_be", 32'(s_be), 32'hC);
    chk("sh_wdata", s_wdata, 32'hABCDABCD);
    chk("sh_addr", s_addr, 32'h100);
    sb_check(32'(wreg_o));
    finish_txn();

    run_access(OP_SB, 32'h101, 32'h000000EE, 1, 32'h0, sc, ep, s_we, s_addr, s_be, s_wdata);
    chk("sb_be", 32'(s_be), 32'h2);
    chk("sb_wdata", s_wdata, 32'hEEEEEEEE);
    finish_txn();

    run_access(OP_SW, 32'h104, 32'h12345678, 1, 32'h0, sc, ep, s_we, s_addr, s_be, s_wdata);
    chk("sw_be", 32'(s_be), 32'hF);
    chk("sw_addr", s_addr, 32'h104);
    chk("sw_wdata", s_wdata, 32'h12345678);
    finish_txn();

    // Misaligned accesses trap with no bus activity and no stall
    @(negedge clk);
    mem_op_i = OP_LW; mem_addr_i = 32'h101; wreg_i = 1'b1;
    #1;
    chk("mis_lw_adel", 32'(exc_adel_o), 32'h1);
    chk("mis_lw_ades", 32'(exc_ades_o), 32'h0);
    chk("mis_lw_stall", 32'(stallreq_o), 32'h0);
    chk("mis_lw_wreg", 32'(wreg_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("mis_lw_req", 32'(dbus_req), 32'h0);
    end
    mem_op_i = OP_LH; mem_addr_i = 32'h101;
    #1;
    chk("mis_lh_adel", 32'(exc_adel_o), 32'h1);
    mem_op_i = OP_SH; mem_addr_i = 32'h103;
    #1;
    chk("mis_sh_ades", 32'(exc_ades_o), 32'h1);
    chk("mis_sh_adel", 32'(exc_adel_o), 32'h0);
    chk("mis_sh_stall", 32'(stallreq_o), 32'h0);
    mem_op_i = OP_SW; mem_addr_i = 32'h102;
    #1;
    chk("mis_sw_ades", 32'(exc_ades_o), 32'h1);
    mem_op_i = OP_NONE;

    // Timeout: 8 BUSY cycles, one bus_err pulse, no register write
    sb_push("tmo_wreg", 32'h0);
    run_access(OP_LW, 32'h200, 32'h0, 0, 32'h0, sc, ep, s_we, s_addr, s_be, s_wdata);
    chk("tmo_stall_cycles", 32'(sc), 32'd9);
    chk("tmo_err_now", 32'(bus_err_o), 32'h1);
    chk("tmo_err_pulses", 32'(ep), 32'd1);
    chk("tmo_req_dropped", 32'(dbus_req), 32'h0);
    sb_check(32'(wreg_o));
    finish_txn();
    chk("tmo_err_gone", 32'(bus_err_o), 32'h0);

    // Reset mid-BUSY drops req at once; ack afterwards in IDLE is ignored
    @(negedge clk);
    mem_op_i = OP_LW; mem_addr_i = 32'h300; dbus_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rb_pre_req", 32'(dbus_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rb_req", 32'(dbus_req), 32'h0);
    chk("rb_stall", 32'(stallreq_o), 32'h0);
    chk("rb_wd", 32'(wd_o), 32'h0);
    mem_op_i = OP_NONE;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF; wdata_i = 32'h5A5A0001;
    #1;
    chk("rb_ack_idle_stall", 32'(stallreq_o), 32'h0);
    chk("rb_ack_idle_wdata", wdata_o, 32'h5A5A0001);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("rb_after_ack_req", 32'(dbus_req), 32'h0);
    chk("rb_after_ack_stall", 32'(stallreq_o), 32'h0);

    // Clean access after reset sees only its own ack data
    sb_push("post_rst_wdata", 32'h01020304);
    run_access(OP_LW, 32'h300, 32'h0, 1, 32'h01020304, sc, ep, s_we, s_addr, s_be, s_wdata);
    sb_check(wdata_o);
    finish_txn();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Next-generation MEM stage of the 5-stage pipeline, between the EX/MEM and MEM/WB pipeline registers.
- Passes ALU and HI/LO results through, as before.
- Adds a load/store unit:
  - drives a req/ack data bus with byte enables;
  - aligns and sign/zero-extends load data;
  - detects misaligned accesses;
  - stalls the pipeline while a bus access is outstanding, with a bounded-wait timeout.

Parameters:
- ADDR_W, 32: data bus address width; effective address input width.
- REG_ADDR_W, 5: destination register address width.
- MAX_WAIT, 16: BUSY cycles without ack before a bus error (range 1..255).
- Data width is fixed at 32. Byte enables are 4 bits, little-endian.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (already decided)
- stall  in  6  pipeline stall vector; stall[4] holds the MEM/WB register
- wdata_i  in  32  ALU result
- wd_i  in  REG_ADDR_W  destination register
- wreg_i  in  1  register write enable
- hi_i, lo_i  in  32 each  HI/LO values
- whilo_i  in  1  HI/LO write enable
- mem_op_i  in  4  access type: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NONE
- mem_addr_i  in  ADDR_W  effective address
- mem_sdata_i  in  32  store data (rt)
- wdata_o  out  32  write-back data
- wd_o  out  REG_ADDR_W  write-back register address
- wreg_o  out  1  write-back enable
- hi_o, lo_o  out  32 each  HI/LO outputs
- whilo_o  out  1  HI/LO write enable
- dbus_req  out  1  bus request
- dbus_we  out  1  bus write
- dbus_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_ack  in  1  bus acknowledge
- dbus_rdata  in  32  read data, valid with ack
- stallreq_o  out  1  stall request to the pipeline control unit
- exc_adel_o  out  1  load address error
- exc_ades_o  out  1  store address error
- bus_err_o  out  1  bus timeout, one pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; timeout counter and load-data register clear.
  - dbus_req, dbus_we, dbus_be, dbus_addr and dbus_wdata are 0.
  - All other outputs are 0 while rst=0, and wd_o=0.
  - Reset mid-access drops dbus_req immediately. A later ack is ignored.
- HI/LO: hi_o, lo_o and whilo_o equal their inputs combinationally, in every state.
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - On a misaligned access:
    - raise exc_adel_o (load) or exc_ades_o (store) combinationally while the op is present;
    - wreg_o=0, no bus access, stallreq_o=0.
- FSM states IDLE, BUSY, DONE.
  - IDLE, with an aligned access op present:
    - stallreq_o=1 combinationally;
    - next state BUSY;
    - register dbus_req=1, dbus_we (1 for stores), dbus_addr, dbus_be and dbus_wdata.
    - Byte enables: byte = 1<<addr[1:0]; half = 0011 or 1100; word = 1111.
    - Store data: SB replicates byte x4; SH replicates half x2.
  - BUSY:
    - stallreq_o=1; bus outputs held stable.
    - On dbus_ack: capture dbus_rdata, deassert dbus_req, go to DONE.
    - Otherwise increment the counter. When the counter reaches MAX_WAIT: pulse bus_err_o for 1 cycle, deassert dbus_req, go to DONE with the load result invalid.
  - DONE:
    - stallreq_o=0; outputs present the result.
    - Return to IDLE when stall[4]=0 (result consumed by MEM/WB). Otherwise hold.
- Load result:
  - Select the byte or half by addr[1:0]/addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - In DONE: wdata_o = loaded value, wreg_o = wreg_i.
  - After a timeout, wreg_o=0.
- Stores: wreg_o=0 in every state.
- Non-memory ops: pure passthrough (wdata_o=wdata_i, wd_o=wd_i, wreg_o=wreg_i). No stall, zero latency.
- wd_o=wd_i always (outside reset).
- Ack received in IDLE or DONE: ignored.

Test Plan:
- ALU passthrough: op NONE, wdata_i=0x12345678, wd_i=3, wreg_i=1, whilo_i=1 → same values on outputs in the same cycle; stallreq_o=0.
- LW at 0x100, ack 3 cycles after req with rdata=0xDEADBEEF:
  - dbus_be=1111 and dbus_addr=0x100;
  - stallreq_o high for the IDLE cycle plus the BUSY cycles;
  - DONE gives wdata_o=0xDEADBEEF, wreg_o=1.
- Byte and half loads, rdata=0x80112233:
  - LB @0x103 → 0xFFFFFF80;
  - LBU @0x103 → 0x00000080;
  - LH @0x102 → 0xFFFF8011;
  - LHU @0x100 → 0x00002233.
- SH @0x102 with sdata=0x0000ABCD → dbus_we=1, dbus_be=1100, dbus_wdata=0xABCDABCD, wreg_o=0 after ack.
- Misaligned:
  - LW @0x101 → exc_adel_o=1, dbus_req never asserted, stallreq_o=0;
  - SH @0x103 → exc_ades_o=1.
- Timeout, MAX_WAIT=8, no ack → bus_err_o pulses once after 8 BUSY cycles, then DONE with wreg_o=0.
- Reset mid-BUSY: drop rst → dbus_req=0 immediately. Release rst → IDLE; an ack during IDLE has no effect.
